// File: rtl/mac_pkg.sv
// Shared encodings for the iterative multiply-accumulate unit: op codes, FSM states,
// default geometry and small decode helpers.
package mac_pkg;

    localparam int MAC_WIDTH = 32;
    localparam int MAC_STEP  = 8;
    localparam int MAC_N     = MAC_WIDTH / MAC_STEP;

    typedef enum logic [2:0] {
        MAC_MULT  = 3'd0,
        MAC_MULTU = 3'd1,
        MAC_MADD  = 3'd2,
        MAC_MADDU = 3'd3,
        MAC_MSUB  = 3'd4,
        MAC_MSUBU = 3'd5
    } mac_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACC  = 2'd2,
        ST_DONE = 2'd3
    } mac_state_e;

    // Counter must hold 0..N inclusive.
    function automatic int mac_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Unknown codes fall back to an unsigned plain multiply.
    function automatic mac_op_e mac_decode_op(input logic [2:0] code);
        case (code)
            3'd0:    return MAC_MULT;
            3'd2:    return MAC_MADD;
            3'd3:    return MAC_MADDU;
            3'd4:    return MAC_MSUB;
            3'd5:    return MAC_MSUBU;
            default: return MAC_MULTU;
        endcase
    endfunction

    function automatic logic mac_is_signed(input mac_op_e op);
        return (op == MAC_MULT) || (op == MAC_MADD) || (op == MAC_MSUB);
    endfunction

endpackage

// File: rtl/mac_step.sv
// One iteration of the multiplier: WIDTH x STEP unsigned partial product,
// positioned at bit cnt*STEP of the 2*WIDTH accumulator. Purely combinational.
module mac_step
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int STEP  = MAC_STEP,
    parameter int CNT_W = 3
) (
    input  logic [WIDTH-1:0]   mcand,
    input  logic [STEP-1:0]    mbits,
    input  logic [CNT_W-1:0]   cnt,
    output logic [2*WIDTH-1:0] addend
);

    logic [WIDTH+STEP-1:0] prod;

    always_comb begin
        prod   = {{STEP{1'b0}}, mcand} * {{WIDTH{1'b0}}, mbits};
        addend = (2*WIDTH)'(prod) << (32'(cnt) * STEP);
    end

endmodule

// File: rtl/mac_unit.sv
// Iterative signed/unsigned MULT/MADD/MSUB against a 2*WIDTH HI/LO accumulator.
// Ready WIDTH/STEP+1 cycles after the start edge; result held in DONE while start_i stays high.
module mac_unit
    import mac_pkg::*;
#(
    parameter int WIDTH = MAC_WIDTH,
    parameter int STEP  = MAC_STEP
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic [2*WIDTH-1:0]   hilo_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = mac_cnt_w(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if ((WIDTH % STEP) != 0 || STEP < 1) begin : g_bad_step
        $error("mac_unit: WIDTH must be a non-zero multiple of STEP");
    end

    mac_state_e           state_q, state_d;
    mac_op_e              op_q;
    logic                 neg_q;
    logic [WIDTH-1:0]     mcand_q, mplier_q;
    logic [2*WIDTH-1:0]   hilo_q, partial_q, result_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ready_q;

    mac_op_e              dec_op;
    logic                 sgn_in;
    logic [2*WIDTH-1:0]   addend, prod, acc_result;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (annul_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_BUSY;
                ST_BUSY: if (cnt_q == CNT_LAST) state_d = ST_ACC;
                ST_ACC:  state_d = ST_DONE;
                ST_DONE: if (!start_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == ST_BUSY) || (state_q == ST_ACC);
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

    mac_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .CNT_W (CNT_W)
    ) u_step (
        .mcand  (mcand_q),
        .mbits  (mplier_q[STEP-1:0]),
        .cnt    (cnt_q),
        .addend (addend)
    );

    always_comb begin
        dec_op = mac_decode_op(op_i);
        sgn_in = mac_is_signed(dec_op);
        prod   = neg_q ? -partial_q : partial_q;
        case (op_q)
            MAC_MADD, MAC_MADDU: acc_result = hilo_q + prod;
            MAC_MSUB, MAC_MSUBU: acc_result = hilo_q - prod;
            default:             acc_result = prod;
        endcase
    end

    // The unsigned core works on magnitudes; sign is reapplied once in ACC.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q      <= MAC_MULT;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            hilo_q    <= '0;
            partial_q <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else if (annul_i) begin
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) begin
                    op_q      <= dec_op;
                    neg_q     <= sgn_in & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    mcand_q   <= (sgn_in && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
                    mplier_q  <= (sgn_in && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
                    hilo_q    <= hilo_i;
                    partial_q <= '0;
                    cnt_q     <= '0;
                end
                ST_BUSY: begin
                    partial_q <= partial_q + addend;
                    mplier_q  <= mplier_q >> STEP;
                    cnt_q     <= cnt_q + CNT_W'(1);
                end
                ST_ACC: begin
                    result_q  <= acc_result;
                    ready_q   <= 1'b1;
                end
                ST_DONE: if (!start_i) begin
                    result_q  <= '0;
                    ready_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_unit.sv
// Bench for mac_unit at WIDTH=32, STEP=8: directed vectors, handshake, annul, reset
// and random ops against a 64-bit reference, results matched through a queue.
module tb_mac_unit;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, annul_i;
    logic [2:0]  op_i;
    logic [31:0] opdata1_i, opdata2_i;
    logic [63:0] hilo_i, result_o;
    logic        ready_o, busy_o;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mac_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .annul_i   (annul_i),
        .op_i      (op_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .hilo_i    (hilo_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] h);
        logic [63:0] p;
        case (op)
            3'd0, 3'd2, 3'd4: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            default:          p = {32'd0, a} * {32'd0, b};
        endcase
        case (op)
            3'd2, 3'd3: return h + p;
            3'd4, 3'd5: return h - p;
            default:    return p;
        endcase
    endfunction

    // Starts at a negedge with the DUT idle; ends at a negedge with the DUT idle again.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] h, input logic [63:0] expv, input int hold,
                          input string name);
        int lat;
        int busy_n;
        logic [63:0] want;
        logic [63:0] held;
        start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b; hilo_i = h;
        exp_q.push_back(expv);
        @(posedge clk); #1;
        op_i = 3'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
        hilo_i = {$urandom, $urandom};
        lat = -1; busy_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy_o) busy_n++;
            if (ready_o) begin lat = k; break; end
        end
        total++;
        if (lat !== MAC_N + 1) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, lat, MAC_N + 1);
        end
        total++;
        if (busy_n !== MAC_N + 1) begin
            bad++; $display("FAIL %s busy cycles: got %0d want %0d", name, busy_n, MAC_N + 1);
        end
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        total++;
        if (result_o !== want) begin
            bad++; $display("FAIL %s result: got %h want %h", name, result_o, want);
        end
        held = want;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            total++;
            if (ready_o !== 1'b1 || result_o !== held || busy_o !== 1'b0) begin
                bad++; $display("FAIL %s hold%0d: got rdy=%b res=%h busy=%b want rdy=1 res=%h busy=0",
                                name, i, ready_o, result_o, busy_o, held);
            end
        end
        start_i = 1'b0;
        @(negedge clk);
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++; $display("FAIL %s drop: got rdy=%b res=%h want rdy=0 res=0", name, ready_o, result_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = '0;
        opdata1_i = '0; opdata2_i = '0; hilo_i = '0;
        repeat (3) @(negedge clk);
        total++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 64'd0) begin
            bad++; $display("FAIL reset: got rdy=%b busy=%b res=%h want 0/0/0", ready_o, busy_o, result_o);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (ready_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL reset idle: got rdy=%b busy=%b want 0/0", ready_o, busy_o);
        end
    endtask

    task automatic test_directed();
        run_op(MAC_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 64'h0, 64'hFFFF_FFFF_FFFF_FFEB, 0, "mult_neg");
        run_op(MAC_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1, 64'hFFFF_FFFE_0000_0002, 0, "maddu_max");
        run_op(MAC_MSUB,  32'd2, 32'd3, 64'h0, 64'hFFFF_FFFF_FFFF_FFFA, 0, "msub_small");
        run_op(MAC_MULT,  32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000, 0, "mult_minneg");
        run_op(3'd7, 32'hFFFF_FFFF, 32'd2, 64'h5, 64'h0000_0001_FFFF_FFFE, 0, "illegal_op");
    endtask

    // Holds start in DONE, then chains a new op straight into the idle cycle.
    task automatic test_back_to_back();
        run_op(MAC_MADD, 32'hFFFF_FFFF, 32'd10, 64'h0000_0000_0000_0064, 64'h5A, 3, "hold3");
        run_op(MAC_MSUBU, 32'd7, 32'd9, 64'h1_0000_0000, 64'hFFFF_FFC1, 0, "chained");
    endtask

    task automatic test_annul();
        int seen;
        start_i = 1'b1; op_i = MAC_MULT; opdata1_i = 32'd5; opdata2_i = 32'd6; hilo_i = '0;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL annul busy: got %b want 0", busy_o);
        end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready_o) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL annul ready: got %0d ready cycles want 0", seen);
        end
        start_i = 1'b1; annul_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; annul_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0) begin
            bad++; $display("FAIL annul_start: got busy=%b rdy=%b want 0/0", busy_o, ready_o);
        end
        run_op(MAC_MULTU, 32'd1234, 32'd5678, 64'h0, 64'd7006652, 0, "after_annul");
    endtask

    task automatic test_reset_acc();
        start_i = 1'b1; op_i = MAC_MADDU; opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h1234_5678;
        hilo_i = 64'h1111;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (MAC_N + 1) @(negedge clk);
        total++;
        if (busy_o !== 1'b1 || ready_o !== 1'b0) begin
            bad++; $display("FAIL acc state: got busy=%b rdy=%b want 1/0", busy_o, ready_o);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        total++;
        if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++; $display("FAIL reset_acc: got busy=%b rdy=%b res=%h want 0/0/0", busy_o, ready_o, result_o);
        end
        repeat (4) @(negedge clk);
        total++;
        if (ready_o !== 1'b0) begin
            bad++; $display("FAIL reset_acc residue: got rdy=%b want 0", ready_o);
        end
        run_op(MAC_MADD, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] corner[5];
        logic [31:0] a, b;
        logic [63:0] h;
        logic [2:0]  op;
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            h  = {$urandom, $urandom};
            run_op(op, a, b, h, model(op, a, b, h), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_annul();
        test_reset_acc();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
